// File: rtl/stopwatch_disp_pkg.sv
// Shared constants for the stopwatch seven-segment scanner: digit patterns,
// blank/dash codes, decimal-point placement and per-field limits.
package stopwatch_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the pattern for numeral 0.
  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal points after MM ones and SS ones, giving MM.SS.CC.
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

  localparam int MAX_MIN = 59;
  localparam int MAX_SEC = 59;
  localparam int MAX_CS  = 99;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    if (d > 4'd9) return SEG_DASH;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/stopwatch_display_scan_bin2bcd_99.sv
// Combinational 7-bit binary to two BCD digits, flagging values above LIMIT.
module bin2bcd_99
  import stopwatch_disp_pkg::*;
#(
  parameter int LIMIT = MAX_CS
) (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       oor_o
);

  assign oor_o  = (bin_i > 7'(LIMIT));
  assign tens_o = 4'(bin_i / 7'd10);
  assign ones_o = 4'(bin_i % 7'd10);

endmodule

// File: rtl/stopwatch_display_scan.sv
// Six-digit MM.SS.CC multiplexed seven-segment scanner with per-frame input snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to blank the minute tens digit when minutes < 10.
module stopwatch_display_scan
  import stopwatch_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            min_i,
  input  logic [5:0]            sec_i,
  input  logic [6:0]            ms_10_i,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam int                CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic                  run_q;
  logic [5:0]            min_q, sec_q;
  logic [6:0]            cs_q;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick, snap;

  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
  logic       min_oor, sec_oor, cs_oor;
  logic [3:0] digit;
  logic       digit_oor;

  bin2bcd_99 #(.LIMIT(MAX_MIN)) u_min (
    .bin_i ({1'b0, min_q}),
    .tens_o(min_tens),
    .ones_o(min_ones),
    .oor_o (min_oor)
  );

  bin2bcd_99 #(.LIMIT(MAX_SEC)) u_sec (
    .bin_i ({1'b0, sec_q}),
    .tens_o(sec_tens),
    .ones_o(sec_ones),
    .oor_o (sec_oor)
  );

  bin2bcd_99 #(.LIMIT(MAX_CS)) u_cs (
    .bin_i (cs_q),
    .tens_o(cs_tens),
    .ones_o(cs_ones),
    .oor_o (cs_oor)
  );

  assign tick = (cnt_q == CNT_MAX);
  assign snap = tick && (idx_q == 3'd5);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
  end

  // Output decode works from the registered idx/shadow, so outputs trail tick by one cycle.
  always_comb begin
    digit     = 4'd0;
    digit_oor = 1'b0;
    case (idx_q)
      3'd0:    begin digit = cs_ones;  digit_oor = cs_oor;  end
      3'd1:    begin digit = cs_tens;  digit_oor = cs_oor;  end
      3'd2:    begin digit = sec_ones; digit_oor = sec_oor; end
      3'd3:    begin digit = sec_tens; digit_oor = sec_oor; end
      3'd4:    begin digit = min_ones; digit_oor = min_oor; end
      3'd5:    begin digit = min_tens; digit_oor = min_oor; end
      default: begin digit = 4'd0;     digit_oor = 1'b1;    end
    endcase

    seg_d = {~DP_MASK[idx_q], digit_oor ? SEG_DASH : seg_of_digit(digit)};
    an_d  = ~(NUM_DIGITS'(1) << idx_q);

    if (LZB && (idx_q == 3'd5) && (min_q < 6'd10)) seg_d = SEG_BLANK;

    // Stay dark until the first snapshot after reset has been taken.
    if (!run_q) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= 3'd5;
      run_q <= 1'b0;
      min_q <= '0;
      sec_q <= '0;
      cs_q  <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (tick) run_q <= 1'b1;
      if (snap) begin
        min_q <= min_i;
        sec_q <= sec_i;
        cs_q  <= ms_10_i;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Self-checking bench for stopwatch_display_scan with SCAN_DIV = 4.
module tb_stopwatch_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 6 * SCAN_DIV;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] MMT0 = 8'hFF;
`else
  localparam logic [7:0] MMT0 = 8'hC0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] min_i = '0;
  logic [5:0] sec_i = '0;
  logic [6:0] ms_10_i = '0;
  logic [7:0] seg_o;
  logic [5:0] an_o;

  always #5 clk = ~clk;

  stopwatch_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .min_i  (min_i),
    .sec_i  (sec_i),
    .ms_10_i(ms_10_i),
    .seg_o  (seg_o),
    .an_o   (an_o)
  );

  typedef struct packed {
    logic [5:0]      mn;
    logic [5:0]      sc;
    logic [6:0]      cs;
    logic [5:0][7:0] seg;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] an;
    logic [7:0] seg;
  } exp_t;

  localparam logic [5:0] AN_TBL [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  exp_t sb[$];
  vec_t tbl[5];
  vec_t v99, v00;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input int mn, input int sc, input int cs,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input logic [7:0] s4, input logic [7:0] s5);
    vec_t v;
    v.mn  = 6'(mn);
    v.sc  = 6'(sc);
    v.cs  = 7'(cs);
    v.seg = {s5, s4, s3, s2, s1, s0};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    min_i   = v.mn;
    sec_i   = v.sc;
    ms_10_i = v.cs;
  endtask

  task automatic check(input string name, input logic [5:0] an_exp, input logic [7:0] seg_exp);
    n_chk++;
    if (an_o === an_exp && seg_o === seg_exp) n_pass++;
    else $display("FAIL %s: an_o=%b seg_o=%h, required an_o=%b seg_o=%h",
                  name, an_o, seg_o, an_exp, seg_exp);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb.pop_front();
      check(e.name, e.an, e.seg);
    end
  endtask

  task automatic push_frame(input string tag, input vec_t v);
    for (int d = 0; d < 6; d++)
      for (int k = 0; k < SCAN_DIV; k++)
        sb.push_back('{$sformatf("%s d%0d c%0d", tag, d, k), AN_TBL[d], v.seg[d]});
  endtask

  // Displays one full frame; optionally drives the next inputs mid-frame (during digit 2).
  task automatic run_frame(input string tag, input vec_t v, input bit drive, input vec_t nxt);
    push_frame(tag, v);
    for (int c = 0; c < FRAME; c++) begin
      step();
      pop_check();
      if (drive && c == 9) apply(nxt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(12, 34, 56,  8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9);
    tbl[1] = mk(0,  0,  0,   8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, MMT0);
    tbl[2] = mk(5,  61, 7,   8'hF8, 8'hC0, 8'h3F, 8'hBF, 8'h12, MMT0);
    tbl[3] = mk(59, 59, 99,  8'h90, 8'h90, 8'h10, 8'h92, 8'h10, 8'h92);
    tbl[4] = mk(60, 0,  100, 8'hBF, 8'hBF, 8'h40, 8'hC0, 8'h3F, 8'hBF);
    v99    = mk(1,  2,  99,  8'h90, 8'h90, 8'h24, 8'hC0, 8'h79, MMT0);
    v00    = mk(1,  2,  0,   8'hC0, 8'hC0, 8'h24, 8'hC0, 8'h79, MMT0);

    rst = 1'b0;
    apply(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset e%0d", i), 6'h3F, 8'hFF);
    end

    rst = 1'b1;
    for (int i = 1; i <= SCAN_DIV; i++) begin
      step();
      check($sformatf("blank after release e%0d", i), 6'h3F, 8'hFF);
    end

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i], 1'b1, (i < 4) ? tbl[i+1] : v99);

    // Upstream counter drops to 0 right after the snapshot edge captured 99.
    ms_10_i = 7'd0;
    run_frame("cs99", v99, 1'b0, v99);

    // Reset asserted while digit 3 is on.
    for (int c = 0; c <= 12; c++) begin
      step();
      check($sformatf("pre-reset c%0d", c), AN_TBL[c / SCAN_DIV], v00.seg[c / SCAN_DIV]);
    end
    rst = 1'b0;
    step();
    check("mid-frame reset", 6'h3F, 8'hFF);
    rst = 1'b1;
    for (int i = 1; i <= SCAN_DIV; i++) begin
      step();
      check($sformatf("blank after re-release e%0d", i), 6'h3F, 8'hFF);
    end
    step();
    check("restart idx0", 6'h3E, v00.seg[0]);

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
